// File: rtl/jtdsp16_rom_aau.sv
// JTDSP16 ROM address arithmetic unit: program counter, pt/pr/pi/i registers,
// interrupt entry/return and the single-level hardware do-loop sequencer.
module jtdsp16_rom_aau #(
   parameter logic [15:0] IRQ_VECTOR   = 16'h0001,
   parameter logic [15:0] ICALL_VECTOR = 16'h0002
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        cen,
   input  logic        goto_ja,
   input  logic        call_ja,
   input  logic        goto_b,
   input  logic        icall,
   input  logic        post_inc,
   input  logic        pc_halt,
   input  logic        xaau_imm_load,
   input  logic        xaau_ram_load,
   input  logic [2:0]  r_field,
   input  logic [11:0] i_field,
   input  logic [15:0] long_imm,
   input  logic [15:0] ram_dout,
   input  logic        ext_irq,
   input  logic        do_start,
   input  logic [10:0] do_data,
   output logic [15:0] rom_addr,
   output logic [15:0] pt,
   output logic [15:0] pr,
   output logic [15:0] pi,
   output logic [11:0] i,
   output logic        in_irq,
   output logic        do_active
);

   logic [15:0] pc_q, pc_d;
   logic [15:0] pt_q, pt_d;
   logic [15:0] pr_q, pr_d;
   logic [15:0] pi_q, pi_d;
   logic [11:0] i_q, i_d;
   logic        in_irq_q, in_irq_d;
   logic        irq_pend_q, irq_pend_d;
   logic        ext_irq_q, ext_irq_d;
   logic        do_active_q, do_active_d;
   logic [15:0] loop_start_q, loop_start_d;
   logic [15:0] loop_end_q, loop_end_d;
   logic [6:0]  cnt_q, cnt_d;

   logic [2:0]  b_sel;
   logic        b_ireturn, b_call;
   logic        any_jump;
   logic        do_ok;
   logic        eff_active;
   logic [15:0] eff_start, eff_end;
   logic [6:0]  eff_cnt;
   logic        irq_edge, irq_take;
   logic        loop_redirect;
   logic [15:0] pc_inc;
   logic [15:0] ld_val;
   logic        ld_any;
   logic        ld_pt, ld_pr, ld_pi, ld_i;
   logic        implicit_pr, implicit_pi;

   // Decode of this cycle's strobes. A do_start takes effect on the very pc
   // it is issued at, so the loop view used below folds in the new values.
   always_comb begin
      b_sel       = i_field[10:8];
      b_ireturn   = goto_b && (b_sel == 3'd1);
      b_call      = goto_b && (b_sel == 3'd3);
      any_jump    = goto_b || call_ja || goto_ja || icall;
      do_ok       = do_start && (do_data[10:7] != 4'd0) && (do_data[6:0] != 7'd0);
      eff_active  = do_ok || do_active_q;
      eff_start   = do_ok ? pc_q : loop_start_q;
      eff_end     = do_ok ? (pc_q + {12'd0, do_data[10:7]} - 16'd1) : loop_end_q;
      eff_cnt     = do_ok ? do_data[6:0] : cnt_q;
      irq_edge    = ext_irq && !ext_irq_q;
      irq_take    = irq_pend_q && !in_irq_q && !eff_active && !any_jump && !pc_halt;
      loop_redirect = eff_active && (pc_q == eff_end) && !pc_halt && !any_jump;
      pc_inc      = pc_q + 16'd1;
      ld_any      = xaau_imm_load || xaau_ram_load;
      ld_val      = xaau_imm_load ? long_imm : ram_dout;
      ld_pt       = ld_any && (r_field == 3'd0);
      ld_pr       = ld_any && (r_field == 3'd1);
      ld_pi       = ld_any && (r_field == 3'd2);
      ld_i        = ld_any && (r_field == 3'd3);
      implicit_pr = call_ja || b_call;
      implicit_pi = icall || irq_take;
   end

   // Program counter priority chain
   always_comb begin
      pc_d = pc_inc;
      if (goto_b) begin
         case (b_sel)
            3'd0:    pc_d = pr_q;
            3'd1:    pc_d = pi_q;
            3'd2:    pc_d = pt_q;
            3'd3:    pc_d = pt_q;
            default: pc_d = pc_inc;
         endcase
      end else if (call_ja || goto_ja) begin
         pc_d = {pc_q[15:12], i_field};
      end else if (icall) begin
         pc_d = ICALL_VECTOR;
      end else if (loop_redirect) begin
         pc_d = (eff_cnt > 7'd1) ? eff_start : pc_inc;
      end else if (pc_halt) begin
         pc_d = pc_q;
      end else if (irq_take) begin
         pc_d = IRQ_VECTOR;
      end
   end

   // Pointer registers: implicit writes from calls/interrupts beat explicit loads
   always_comb begin
      pt_d = pt_q;
      if (ld_pt)
         pt_d = ld_val;
      else if (post_inc)
         pt_d = pt_q + {{4{i_q[11]}}, i_q};

      pr_d = pr_q;
      if (implicit_pr)
         pr_d = pc_q;
      else if (ld_pr)
         pr_d = ld_val;

      pi_d = pi_q;
      if (implicit_pi)
         pi_d = pc_q;
      else if (ld_pi)
         pi_d = ld_val;

      i_d = ld_i ? ld_val[11:0] : i_q;
   end

   // Interrupt state; a new edge in the same cycle as entry stays pending
   always_comb begin
      ext_irq_d  = ext_irq;
      irq_pend_d = (irq_pend_q && !irq_take) || irq_edge;
      in_irq_d   = in_irq_q;
      if (b_ireturn)
         in_irq_d = 1'b0;
      else if (implicit_pi)
         in_irq_d = 1'b1;
   end

   // Do-loop sequencer
   always_comb begin
      do_active_d  = eff_active;
      loop_start_d = eff_start;
      loop_end_d   = eff_end;
      cnt_d        = eff_cnt;
      if (loop_redirect) begin
         if (eff_cnt > 7'd1)
            cnt_d = eff_cnt - 7'd1;
         else
            do_active_d = 1'b0;
      end
      if (any_jump)
         do_active_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= 16'd0;
         pt_q         <= 16'd0;
         pr_q         <= 16'd0;
         pi_q         <= 16'd0;
         i_q          <= 12'd0;
         in_irq_q     <= 1'b0;
         irq_pend_q   <= 1'b0;
         ext_irq_q    <= 1'b0;
         do_active_q  <= 1'b0;
         loop_start_q <= 16'd0;
         loop_end_q   <= 16'd0;
         cnt_q        <= 7'd0;
      end else if (cen) begin
         pc_q         <= pc_d;
         pt_q         <= pt_d;
         pr_q         <= pr_d;
         pi_q         <= pi_d;
         i_q          <= i_d;
         in_irq_q     <= in_irq_d;
         irq_pend_q   <= irq_pend_d;
         ext_irq_q    <= ext_irq_d;
         do_active_q  <= do_active_d;
         loop_start_q <= loop_start_d;
         loop_end_q   <= loop_end_d;
         cnt_q        <= cnt_d;
      end
   end

   assign rom_addr  = pc_q;
   assign pt        = pt_q;
   assign pr        = pr_q;
   assign pi        = pi_q;
   assign i         = i_q;
   assign in_irq    = in_irq_q;
   assign do_active = do_active_q;

endmodule

// File: doc/jtdsp16_rom_aau.md
Name: jtdsp16_rom_aau

Overview:
- ROM address arithmetic unit (XAAU) of JTDSP16; sits directly downstream of the instruction decoder.
- Consumes its jump, call, return, halt, register-load, IRQ and do-loop strobes.
- Owns the program counter and drives the program ROM address. rom_dout from the ROM feeds back into the decoder.
- Holds pt, pr, pi, i, the interrupt state and the hardware do-loop sequencer.

Parameters:
- IRQ_VECTOR, 16'h0001, pc target on a taken external interrupt
- ICALL_VECTOR, 16'h0002, pc target on icall

Ports:
- rst  in  1  asynchronous active-high reset
- clk  in  1  clock
- cen  in  1  clock enable; all state advances only when high
- goto_ja  in  1  jump to 12-bit JA
- call_ja  in  1  call to 12-bit JA
- goto_b  in  1  B-type branch; selector in i_field[10:8]
- icall  in  1  software interrupt call
- post_inc  in  1  pt <= pt + sign-extended i
- pc_halt  in  1  hold pc this cycle
- xaau_imm_load  in  1  load register r_field from long_imm
- xaau_ram_load  in  1  load register r_field from ram_dout
- r_field  in  3  0=pt 1=pr 2=pi 3=i; 4-7 ignored
- i_field  in  12  instruction immediate/JA field
- long_imm  in  16  immediate data
- ram_dout  in  16  data RAM read data
- ext_irq  in  1  external interrupt request, level
- do_start  in  1  start hardware loop
- do_data  in  11  [10:7]=N body length, [6:0]=K iterations
- rom_addr  out  16  program ROM address (= pc register)
- pt, pr, pi  out  16  pointer, return, interrupt-return registers
- i  out  12  pointer increment register
- in_irq  out  1  executing inside an interrupt routine
- do_active  out  1  hardware loop running

Behaviour:
- Reset (async, rst high): pc, pt, pr, pi = 0; i = 0; in_irq = 0; irq_pend = 0; do_active = 0; loop counters = 0. rom_addr = 0 during reset.
- All updates occur on posedge clk with cen=1. With cen=0 every register holds.
- pc next-value priority (highest first):
  1. goto_b with i_field[10:8]: 0 return, pc<=pr. 1 ireturn, pc<=pi, in_irq<=0. 2 goto pt, pc<=pt. 3 call pt, pr<=pc, pc<=pt. Values 4-7 give plain increment.
  2. call_ja: pr <= pc; pc <= {pc[15:12], i_field}.
  3. goto_ja: pc <= {pc[15:12], i_field}.
  4. icall: pi <= pc; pc <= ICALL_VECTOR; in_irq <= 1.
  5. Loop redirect.
  6. pc_halt: pc holds.
  7. IRQ entry.
  8. Otherwise pc <= pc + 1, wrapping 16'hFFFF -> 0.
- Any jump, call or B-branch with do_active=1 aborts the loop: do_active <= 0.
- Register loads:
  - pt/pr/pi take the full 16 bits; i takes bits [11:0].
  - imm load takes precedence over ram load if both are asserted.
  - Same-cycle implicit writes override explicit loads: pr on call, pi on icall/IRQ entry.
- post_inc: pt <= pt + {{4{i[11]}}, i}, modulo 2^16. It is ignored if a pt load happens in the same cycle.
- IRQ:
  - A rising edge of ext_irq (registered history) sets irq_pend.
  - The IRQ is taken when irq_pend=1, in_irq=0, do_active=0 and no jump, call, icall or pc_halt is present that cycle.
  - On entry: pi <= pc; pc <= IRQ_VECTOR; in_irq <= 1; irq_pend <= 0.
  - Edges arriving while in_irq=1 stay pending until ireturn.
- Do loop:
  - On do_start with N != 0 and K != 0: loop_start <= pc, loop_end <= pc + N - 1, cnt <= K, do_active <= 1. The pc value at do_start is the first body address.
  - do_start with N=0 or K=0 is ignored.
  - While active, when pc == loop_end and pc would otherwise advance (no pc_halt): if cnt > 1, pc <= loop_start and cnt <= cnt - 1. If cnt == 1, pc <= pc + 1 and do_active <= 0.
  - pc_halt on loop_end defers the redirect to the cycle the halt releases.
  - do_start while already active restarts the loop with the new values (no nesting).

Test Plan:
- Reset, then cen=1 for 5 cycles -> rom_addr 0,1,2,3,4. Then cen low 3 cycles -> rom_addr holds 4.
- pc=0x1234, call_ja, i_field=0x056 -> pc=0x1056, pr=0x1234. Next goto_b sel 0 -> pc=0x1234.
- Load pt=0x0100 (imm), i=0xFFE (ram). Then post_inc twice -> pt=0x00FE, 0x00FC.
- pc=0x0020, do_start N=3 K=2 -> rom_addr sequence 0x20,21,22,20,21,22,23, with do_active low after the last 0x22.
- ext_irq rises at pc=0x0040 -> pi=0x0040, pc=0x0001, in_irq=1. A second edge stays pending. ireturn -> pc=0x0040, in_irq=0. The pending IRQ is taken next cycle.
- ext_irq edge during an active loop plus pc_halt at loop_end -> no IRQ until the loop ends, and the redirect is delayed by exactly the halt cycles.
